mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-cache line reads and D-cache line reads/writes onto one memory port.
// Conflict policy: D always wins by default; define ARB_ROUND_ROBIN_EN to alternate between the two sides.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned LINE_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_grant,
    output logic                 i_done,
    output logic [LINE_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [LINE_SIZE-1:0] d_wdata,
    output logic                 d_grant,
    output logic                 d_done,
    output logic [LINE_SIZE-1:0] d_rdata,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [LINE_SIZE-1:0] m_wdata,
    input  logic                 m_ready,
    input  logic [LINE_SIZE-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   i_grant_q, i_grant_d;
    logic                   d_grant_q, d_grant_d;
    logic                   i_done_q, i_done_d;
    logic                   d_done_q, d_done_d;
    logic [LINE_SIZE-1:0]   i_rdata_q, i_rdata_d;
    logic [LINE_SIZE-1:0]   d_rdata_q, d_rdata_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [LINE_SIZE-1:0]   wdata_q, wdata_d;
    logic                   d_wins_c;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when D should win the next conflict, i.e. I was granted most recently.
    logic                   prio_d_q, prio_d_d;
    assign d_wins_c = d_req && (!i_req || prio_d_q);
`else
    assign d_wins_c = d_req;
`endif

    assign i_grant   = i_grant_q;
    assign d_grant   = d_grant_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign m_readM   = rd_q;
    assign m_writeM  = wr_q;
    assign m_address = addr_q;
    assign m_wdata   = wdata_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_d_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            i_grant_q <= i_grant_d;
            d_grant_q <= d_grant_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            prio_d_q  <= prio_d_d;
`endif
        end
    end

    // Next-state and next-output logic; grant and done are single-cycle pulses.
    always_comb begin
        state_d   = state_q;
        i_grant_d = 1'b0;
        d_grant_d = 1'b0;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        prio_d_d  = prio_d_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (d_wins_c) begin
                    state_d   = BUSY_D;
                    d_grant_d = 1'b1;
                    rd_d      = !d_we;
                    wr_d      = d_we;
                    addr_d    = d_addr;
                    wdata_d   = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_d_d  = 1'b0;
`endif
                end else if (i_req) begin
                    state_d   = BUSY_I;
                    i_grant_d = 1'b1;
                    rd_d      = 1'b1;
                    wr_d      = 1'b0;
                    addr_d    = i_addr;
                    wdata_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_d_d  = 1'b1;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready) begin
                    state_d = RESP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (state_q == BUSY_D) begin
                        d_done_d = 1'b1;
                        if (!wr_q) d_rdata_d = m_rdata;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle, plus literal
// expectations for single reads/writes, conflicts, stalls and mid-transaction reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_grant, i_done;
    logic [63:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_grant, d_done;
    logic [63:0] d_rdata;
    logic        m_readM, m_writeM;
    logic [15:0] m_address;
    logic [63:0] m_wdata;
    logic        m_ready = 1'b0;
    logic [63:0] m_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mem_port_arbiter #(.WORD_SIZE(16), .LINE_SIZE(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_done(d_done), .d_rdata(d_rdata),
        .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transfer, its owner, and each side's last read line.
    logic        md_busy = 1'b0, md_first = 1'b0, md_resp = 1'b0, md_d = 1'b0, md_we = 1'b0;
    logic [15:0] md_addr = '0;
    logic [63:0] md_wdata = '0, md_irdata = '0, md_drdata = '0;
    logic        md_pick_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic        md_last_d = 1'b0;
    assign md_pick_d = d_req && (!i_req || !md_last_d);
`else
    assign md_pick_d = d_req;
`endif

    always @(posedge clk) begin
        if (!reset_n) begin
            md_busy <= 1'b0; md_first <= 1'b0; md_resp <= 1'b0; md_d <= 1'b0; md_we <= 1'b0;
            md_addr <= '0; md_wdata <= '0; md_irdata <= '0; md_drdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            md_last_d <= 1'b0;
`endif
        end else if (md_resp) begin
            md_resp <= 1'b0;
        end else if (md_busy) begin
            md_first <= 1'b0;
            if (m_ready) begin
                md_busy <= 1'b0;
                md_resp <= 1'b1;
                if (!md_we && md_d)  md_drdata <= m_rdata;
                if (!md_we && !md_d) md_irdata <= m_rdata;
            end
        end else if (i_req || d_req) begin
            md_busy  <= 1'b1;
            md_first <= 1'b1;
            md_d     <= md_pick_d;
            md_we    <= md_pick_d ? d_we : 1'b0;
            md_addr  <= md_pick_d ? d_addr : i_addr;
            md_wdata <= md_pick_d ? d_wdata : 64'h0;
`ifdef ARB_ROUND_ROBIN_EN
            md_last_d <= md_pick_d;
`endif
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("i_grant",   64'(i_grant),   64'(md_first && !md_d));
            chk("d_grant",   64'(d_grant),   64'(md_first && md_d));
            chk("i_done",    64'(i_done),    64'(md_resp && !md_d));
            chk("d_done",    64'(d_done),    64'(md_resp && md_d));
            chk("m_readM",   64'(m_readM),   64'(md_busy && !md_we));
            chk("m_writeM",  64'(m_writeM),  64'(md_busy && md_we));
            chk("m_address", 64'(m_address), 64'(md_addr));
            chk("m_wdata",   m_wdata,        md_wdata);
            chk("i_rdata",   i_rdata,        md_irdata);
            chk("d_rdata",   d_rdata,        md_drdata);
        end
    end

    // Memory responder: raises m_ready after mem_delay stalled BUSY cycles.
    bit          mem_auto = 1'b1;
    int          mem_delay = 0;
    int          mem_cnt = 0;
    logic [63:0] mem_line = '0;

    initial forever begin
        @(posedge clk);
        #1;
        if (mem_auto) begin
            m_rdata = mem_line;
            if (m_readM || m_writeM) begin
                m_ready = (mem_cnt >= mem_delay);
                mem_cnt++;
            end else begin
                m_ready = 1'b0;
                mem_cnt = 0;
            end
        end
    end

    logic [7:0]  order_bits;
    int          busy_n, done_n;
    logic [15:0] cap_addr;
    logic [63:0] cap_wdata, cap_i_rdata, cap_d_rdata;
    logic        cap_rd, cap_wr, cap_i_done, cap_d_done;

    // Raise the requested sides, drop each req on its grant, return after all dones.
    task automatic serve(input bit want_i, input bit want_d, input bit dwe,
                         input logic [15:0] ia, input logic [15:0] da, input logic [63:0] dwd);
        int left;
        left = int'(want_i) + int'(want_d);
        i_req = want_i; i_addr = ia;
        d_req = want_d; d_we = dwe; d_addr = da; d_wdata = dwd;
        for (int c = 0; c < 200 && left > 0; c++) begin
            @(posedge clk);
            #1;
            if (i_grant) begin i_req = 1'b0; order_bits = {order_bits[6:0], 1'b0}; end
            if (d_grant) begin d_req = 1'b0; order_bits = {order_bits[6:0], 1'b1}; end
            if (m_readM || m_writeM) begin
                busy_n++;
                cap_addr = m_address; cap_wdata = m_wdata; cap_rd = m_readM; cap_wr = m_writeM;
            end
            if (i_done || d_done) begin
                left--;
                done_n++;
                cap_i_done = i_done; cap_d_done = d_done;
                cap_i_rdata = i_rdata; cap_d_rdata = d_rdata;
            end
        end
        chk("serve_timeout", 64'(left), 64'd0);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int dn;
        bit got;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_m_readM",   64'(m_readM),   64'd0);
        chk("rst_m_address", 64'(m_address), 64'd0);
        chk("rst_i_rdata",   i_rdata,        64'd0);
        chk("rst_d_grant",   64'(d_grant),   64'd0);

        // Single I read at minimum latency.
        mem_delay = 0; mem_line = 64'h0123_4567_89AB_CDEF; busy_n = 0;
        serve(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 64'h0);
        chk("iread_rd",    64'(cap_rd),     64'd1);
        chk("iread_addr",  64'(cap_addr),   64'h0010);
        chk("iread_busy",  64'(busy_n),     64'd1);
        chk("iread_idone", 64'(cap_i_done), 64'd1);
        chk("iread_ddone", 64'(cap_d_done), 64'd0);
        chk("iread_rdata", cap_i_rdata,     64'h0123_4567_89AB_CDEF);

        // D read then D write: the write must leave d_rdata untouched.
        mem_line = 64'hDEAD_BEEF_CAFE_F00D;
        serve(1'b0, 1'b1, 1'b0, 16'h0, 16'h0040, 64'h0);
        chk("dread_rdata", cap_d_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        mem_line = 64'h1111_2222_3333_4444;
        serve(1'b0, 1'b1, 1'b1, 16'h0, 16'h0040, 64'hFFFF_0000_FFFF_0000);
        chk("dwr_wr",    64'(cap_wr),     64'd1);
        chk("dwr_rd",    64'(cap_rd),     64'd0);
        chk("dwr_addr",  64'(cap_addr),   64'h0040);
        chk("dwr_wdata", cap_wdata,       64'hFFFF_0000_FFFF_0000);
        chk("dwr_ddone", 64'(cap_d_done), 64'd1);
        chk("dwr_idone", 64'(cap_i_done), 64'd0);
        chk("dwr_rdata", cap_d_rdata,     64'hDEAD_BEEF_CAFE_F00D);

        // Stall of 5 cycles per transfer with the loser waiting throughout.
        mem_delay = 5; busy_n = 0; done_n = 0; mem_line = 64'h5555_6666_7777_8888;
        serve(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0030, 64'h0);
        chk("stall_busy",  64'(busy_n), 64'd12);
        chk("stall_dones", 64'(done_n), 64'd2);
        mem_delay = 0;

        // Three conflicts after reset: D then I each time under either policy.
        do_reset();
        order_bits = '0;
        for (int k = 0; k < 3; k++) begin
            mem_line = 64'hA000_0000_0000_0000 + 64'(k);
            serve(1'b1, 1'b1, 1'b0, 16'h0100 + 16'(k), 16'h0200 + 16'(k), 64'h0);
        end
        chk("conflict_order", 64'(order_bits[5:0]), 64'b101010);

        // Lone D grant followed by a conflict separates the two policies.
        do_reset();
        order_bits = '0;
        serve(1'b0, 1'b1, 1'b0, 16'h0, 16'h0300, 64'h0);
        serve(1'b1, 1'b1, 1'b0, 16'h0310, 16'h0320, 64'h0);
`ifdef ARB_ROUND_ROBIN_EN
        chk("policy_order", 64'(order_bits[2:0]), 64'b101);
`else
        chk("policy_order", 64'(order_bits[2:0]), 64'b110);
`endif

        // Reset during BUSY_D, then a stray m_ready: no done, everything cleared.
        mem_auto = 1'b0;
        m_ready = 1'b0;
        m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk);
            #1;
            got = d_grant;
        end
        chk("rst_op_grant", 64'(got), 64'd1);
        d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_op_busy", 64'(m_readM), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_ready = 1'b1;
        chk("rst_op_readM",   64'(m_readM),   64'd0);
        chk("rst_op_address", 64'(m_address), 64'd0);
        chk("rst_op_drdata",  d_rdata,        64'd0);
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            m_ready = 1'b0;
            if (d_done) dn++;
            if (m_readM || m_writeM) dn++;
        end
        chk("rst_op_nodone", 64'(dn), 64'd0);
        mem_auto = 1'b1;

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
